// File: rtl/jtkicker_sdram_resp_if.sv
// Bundle of the ROM-slot request, download-write and memory-port signals around
// jtkicker_sdram_resp. The responder uses the slave view; the game/memory side uses master.
interface jtkicker_sdram_resp_if;
  logic        downloading;
  logic        sdram_req;
  logic [21:0] sdram_addr;
  logic        sdram_ack;
  logic        data_dst;
  logic        data_rdy;
  logic [15:0] data_read;
  logic        prog_we;
  logic [21:0] prog_addr;
  logic [7:0]  prog_data;
  logic [1:0]  prog_mask;
  logic [21:0] mem_addr;
  logic        mem_rd;
  logic        mem_we;
  logic [1:0]  mem_be;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  modport slave (
    input  downloading, sdram_req, sdram_addr,
    input  prog_we, prog_addr, prog_data, prog_mask,
    input  mem_rdata,
    output sdram_ack, data_dst, data_rdy, data_read,
    output mem_addr, mem_rd, mem_we, mem_be, mem_wdata
  );

  modport master (
    output downloading, sdram_req, sdram_addr,
    output prog_we, prog_addr, prog_data, prog_mask,
    output mem_rdata,
    input  sdram_ack, data_dst, data_rdy, data_read,
    input  mem_addr, mem_rd, mem_we, mem_be, mem_wdata
  );
endinterface

// File: rtl/jtkicker_sdram_resp.sv
// SDRAM request responder: serves 2-word read bursts and download byte writes onto a
// 16-bit synchronous memory with 1-cycle read latency, inserting periodic refresh stalls.
module jtkicker_sdram_resp #(
  parameter int unsigned LATENCY     = 4,
  parameter int unsigned REFRESH_INT = 780,
  parameter int unsigned REFRESH_LEN = 8,
  parameter int unsigned WR_GAP      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  jtkicker_sdram_resp_if.slave  bus
);

  localparam int unsigned RW = (REFRESH_INT < 2) ? 1 : $clog2(REFRESH_INT + 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_W0,
    RD_W1,
    WR_REC,
    REFRESH
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [RW-1:0] rfsh_q, rfsh_d;
  logic [21:0]   a0_q, a0_d;
  logic          ack_q, ack_d;
  logic          dst_q, dst_d;
  logic          rdy_q, rdy_d;
  logic          rd_q, rd_d;
  logic          we_q, we_d;
  logic [1:0]    be_q, be_d;
  logic [21:0]   maddr_q, maddr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [15:0]   last_q, last_d;
  logic          rfsh_sat;
  logic          rfsh_due;

  assign rfsh_sat = (rfsh_q == RW'(REFRESH_INT));
  assign rfsh_due = (REFRESH_INT != 0) && rfsh_sat;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a0_d    = a0_q;
    ack_d   = 1'b0;
    dst_d   = 1'b0;
    rdy_d   = 1'b0;
    rd_d    = 1'b0;
    we_d    = 1'b0;
    be_d    = be_q;
    maddr_d = maddr_q;
    wdata_d = wdata_q;
    last_d  = last_q;
    rfsh_d  = rfsh_sat ? rfsh_q : rfsh_q + 1'b1;

    // Burst words come straight from mem_rdata; keep the last one for the hold value.
    if (dst_q || rdy_q) last_d = bus.mem_rdata;

    case (state_q)
      IDLE: begin
        if (rfsh_due) begin
          state_d = REFRESH;
          cnt_d   = 8'(REFRESH_LEN - 1);
          rfsh_d  = '0;
        end else if (bus.downloading && bus.prog_we) begin
          state_d = WR_REC;
          cnt_d   = 8'(WR_GAP);
          ack_d   = 1'b1;
          we_d    = 1'b1;
          maddr_d = bus.prog_addr;
          wdata_d = {bus.prog_data, bus.prog_data};
          be_d    = ~bus.prog_mask;
        end else if (!bus.downloading && bus.sdram_req) begin
          state_d = RD_WAIT;
          cnt_d   = 8'(LATENCY - 1);
          ack_d   = 1'b1;
          a0_d    = bus.sdram_addr;
        end
      end
      RD_WAIT: begin
        // cnt_q counts down to the cycle before the first data word.
        if (cnt_q == 8'd0) begin
          state_d = RD_W0;
          rd_d    = 1'b1;
          maddr_d = a0_q + 22'd1;
          dst_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            rd_d    = 1'b1;
            maddr_d = a0_q;
          end
        end
      end
      RD_W0: begin
        state_d = RD_W1;
        rdy_d   = 1'b1;
      end
      RD_W1: begin
        state_d = IDLE;
      end
      WR_REC, REFRESH: begin
        if (cnt_q == 8'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rfsh_q  <= '0;
      a0_q    <= '0;
      ack_q   <= 1'b0;
      dst_q   <= 1'b0;
      rdy_q   <= 1'b0;
      rd_q    <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      maddr_q <= '0;
      wdata_q <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rfsh_q  <= rfsh_d;
      a0_q    <= a0_d;
      ack_q   <= ack_d;
      dst_q   <= dst_d;
      rdy_q   <= rdy_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      be_q    <= be_d;
      maddr_q <= maddr_d;
      wdata_q <= wdata_d;
      last_q  <= last_d;
    end
  end

  assign bus.sdram_ack = ack_q;
  assign bus.data_dst  = dst_q;
  assign bus.data_rdy  = rdy_q;
  assign bus.data_read = (dst_q || rdy_q) ? bus.mem_rdata : last_q;
  assign bus.mem_addr  = maddr_q;
  assign bus.mem_rd    = rd_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_be    = be_q;
  assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_jtkicker_sdram_resp.sv
// Directed bench for jtkicker_sdram_resp: reads, address wrap, writes, priority,
// refresh stalls under continuous requests, and reset in the middle of a burst.
module tb_jtkicker_sdram_resp;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  int   excl_bad = 0;

  jtkicker_sdram_resp_if bus();

  jtkicker_sdram_resp #(
    .LATENCY    (4),
    .REFRESH_INT(20),
    .REFRESH_LEN(8),
    .WR_GAP     (2)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [logic [21:0]];

  function automatic logic [15:0] mem_word(input logic [21:0] a);
    return mem.exists(a) ? mem[a] : 16'hDEAD;
  endfunction

  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_rdata <= mem_word(bus.mem_addr);
    if (bus.mem_we) begin
      logic [15:0] w;
      w = mem_word(bus.mem_addr);
      if (bus.mem_be[0]) w[7:0]  = bus.mem_wdata[7:0];
      if (bus.mem_be[1]) w[15:8] = bus.mem_wdata[15:8];
      mem[bus.mem_addr] = w;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if ((bus.mem_rd && (bus.mem_we || bus.sdram_ack)) || (bus.data_dst && bus.data_rdy)
          || (bus.sdram_ack && bus.mem_we && bus.mem_rd))
        excl_bad++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ack(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (bus.sdram_ack) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic do_read(input string tag, input logic [21:0] a,
                         input logic [15:0] w0, input logic [15:0] w1);
    int n;
    int early;
    logic [21:0] a1;
    a1 = a + 22'd1;
    early = 0;
    bus.sdram_addr = a;
    bus.sdram_req  = 1'b1;
    wait_ack(100, n);
    bus.sdram_req = 1'b0;
    check({tag, "_ack"}, (n > 0), 1);
    if (n <= 0) return;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) check({tag, "_ack_pulse"}, bus.sdram_ack, 0);
      if (k <= 3 && (bus.data_dst || bus.data_rdy)) early++;
      if (k == 3) begin
        check({tag, "_rd0"}, bus.mem_rd, 1);
        check({tag, "_addr0"}, bus.mem_addr, a);
      end
      if (k == 4) begin
        check({tag, "_early"}, early, 0);
        check({tag, "_dst"}, {bus.data_dst, bus.data_rdy}, 2'b10);
        check({tag, "_w0"}, bus.data_read, w0);
        check({tag, "_addr1"}, bus.mem_addr, a1);
      end
      if (k == 5) begin
        check({tag, "_rdy"}, {bus.data_dst, bus.data_rdy}, 2'b01);
        check({tag, "_w1"}, bus.data_read, w1);
      end
      if (k == 6) begin
        check({tag, "_hold"}, bus.data_read, w1);
        check({tag, "_end"}, {bus.data_dst, bus.data_rdy, bus.mem_rd}, 3'b000);
      end
    end
  endtask

  initial begin
    int n;
    int cnt;
    int cyc, last, gap, mingap, longs, acks, nd, nr, bad;

    mem[22'h000100] = 16'hA1B2;
    mem[22'h000101] = 16'hC3D4;
    mem[22'h3FFFFF] = 16'h1357;
    mem[22'h000000] = 16'h2468;
    mem[22'h000020] = 16'h1234;

    bus.downloading = 1'b0;
    bus.sdram_req   = 1'b0;
    bus.sdram_addr  = '0;
    bus.prog_we     = 1'b0;
    bus.prog_addr   = '0;
    bus.prog_data   = '0;
    bus.prog_mask   = 2'b11;
    bus.mem_rdata   = '0;

    repeat (3) @(negedge clk);
    check("rst_outs", {bus.sdram_ack, bus.data_dst, bus.data_rdy, bus.mem_rd, bus.mem_we}, 5'b0);
    check("rst_data", {bus.data_read, bus.mem_addr}, 38'h0);
    rst = 1'b0;
    @(negedge clk);

    do_read("rd100", 22'h000100, 16'hA1B2, 16'hC3D4);
    do_read("wrap", 22'h3FFFFF, 16'h1357, 16'h2468);

    // Write with lower lane only, prog_we held across recovery
    bus.downloading = 1'b1;
    bus.prog_addr   = 22'h000020;
    bus.prog_data   = 8'h5A;
    bus.prog_mask   = 2'b10;
    bus.prog_we     = 1'b1;
    wait_ack(100, n);
    check("wr_ack", (n > 0), 1);
    check("wr_strobe", {bus.mem_we, bus.mem_rd}, 2'b10);
    check("wr_be", bus.mem_be, 2'b01);
    check("wr_wdata", bus.mem_wdata, 16'h5A5A);
    check("wr_addr", bus.mem_addr, 22'h000020);
    wait_ack(100, n);
    bus.prog_we = 1'b0;
    check("wr_gap", (n >= 3), 1);

    bus.prog_mask = 2'b11;
    bus.prog_addr = 22'h000040;
    bus.prog_we   = 1'b1;
    wait_ack(100, n);
    bus.prog_we = 1'b0;
    check("wr_mask_ack", (n > 0), 1);
    check("wr_mask_be", {bus.mem_we, bus.mem_be}, 3'b100);
    bus.downloading = 1'b0;

    do_read("rd20", 22'h000020, 16'h125A, 16'hDEAD);

    // Both requests while downloading: the write wins, the read waits
    bus.downloading = 1'b1;
    bus.sdram_addr  = 22'h000100;
    bus.sdram_req   = 1'b1;
    bus.prog_addr   = 22'h000030;
    bus.prog_data   = 8'h77;
    bus.prog_mask   = 2'b00;
    bus.prog_we     = 1'b1;
    wait_ack(100, n);
    bus.prog_we = 1'b0;
    check("prio_wr", {bus.mem_we, bus.mem_rd, bus.mem_be}, 4'b1011);
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.sdram_ack) cnt++;
    end
    check("prio_noack", cnt, 0);
    bus.downloading = 1'b0;
    do_read("prio_rd", 22'h000100, 16'hA1B2, 16'hC3D4);

    // Continuous requests: refresh stalls open long ack gaps, bursts stay intact
    bus.sdram_addr = 22'h000100;
    bus.sdram_req  = 1'b1;
    cyc = 0; last = -1; mingap = 1000; longs = 0; acks = 0; nd = 0; nr = 0; bad = 0;
    for (int i = 0; i < 320; i++) begin
      @(negedge clk);
      cyc++;
      if (i == 299) bus.sdram_req = 1'b0;
      if (bus.sdram_ack) begin
        if (last >= 0) begin
          gap = cyc - last;
          if (gap < mingap) mingap = gap;
          if (gap >= 14) longs++;
        end
        last = cyc;
        acks++;
      end
      if (bus.data_dst) begin
        nd++;
        if (bus.data_read != 16'hA1B2) bad++;
      end
      if (bus.data_rdy) begin
        nr++;
        if (bus.data_read != 16'hC3D4) bad++;
      end
    end
    check("rf_acks", (acks >= 10), 1);
    check("rf_dst", nd, acks);
    check("rf_rdy", nr, acks);
    check("rf_data", bad, 0);
    check("rf_mingap", (mingap >= 6), 1);
    check("rf_stalls", (longs >= 5), 1);

    // Reset two cycles after the ack of a read
    bus.sdram_addr = 22'h000100;
    bus.sdram_req  = 1'b1;
    wait_ack(100, n);
    bus.sdram_req = 1'b0;
    check("mr_ack", (n > 0), 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mr_outs", {bus.sdram_ack, bus.data_dst, bus.data_rdy, bus.mem_rd, bus.mem_we}, 5'b0);
    check("mr_data", {bus.data_read, bus.mem_addr, bus.mem_be, bus.mem_wdata}, 56'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.data_dst || bus.data_rdy || bus.mem_rd) cnt++;
    end
    check("mr_no_burst", cnt, 0);
    do_read("mr_rd", 22'h000101, 16'hC3D4, 16'hDEAD);

    check("exclusive", excl_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
